// File: rtl/seq_slt_unit.sv
// Multi-cycle set-less-than / equality unit: A - B computed as A + ~B + 1, CHUNK bits per cycle, LSB chunk first.
// Latency: start accepted at edge k -> done_o high after edge k+NCH; one compare every NCH+1 cycles.
// Backpressure: start_i is only accepted while busy_o=0; requests during busy are dropped, not queued.
module seq_slt_unit #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             lt_o,
    output logic             eq_o
);

    localparam int NCH = WIDTH / CHUNK;
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;

    // Reject geometries the chunk walk cannot cover exactly.
    generate
        if ((WIDTH % CHUNK) != 0 || WIDTH < 2) begin : g_param_err
            $error("seq_slt_unit: WIDTH must be >= 2 and a multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              carry_q, carry_d;
    logic              eq_acc_q, eq_acc_d;
    logic              sgn_q, sgn_d;
    logic [WIDTH-1:0]  a_q, a_d;
    // B is stored already inverted so the adder only ever adds.
    logic [WIDTH-1:0]  nb_q, nb_d;
    logic              done_q, done_d;
    logic              lt_q, lt_d;
    logic              eq_q, eq_d;

    logic [CHUNK-1:0]  a_chunk;
    logic [CHUNK-1:0]  nb_chunk;
    logic [CHUNK:0]    sum_full;
    logic              cout;
    logic              s_msb;
    logic              c_into_msb;
    logic              ov;
    logic              chunk_eq;
    logic              last_chunk;

    // Select the operand chunk addressed by the counter (plain mux, no variable part-select).
    always_comb begin
        a_chunk  = '0;
        nb_chunk = '0;
        for (int i = 0; i < NCH; i++) begin
            if (cnt_q == CW'(i)) begin
                a_chunk  = a_q[i*CHUNK +: CHUNK];
                nb_chunk = nb_q[i*CHUNK +: CHUNK];
            end
        end
    end

    // One chunk of A + ~B + carry, plus the flags needed if this is the top chunk.
    always_comb begin
        sum_full   = {1'b0, a_chunk} + {1'b0, nb_chunk} + {{CHUNK{1'b0}}, carry_q};
        cout       = sum_full[CHUNK];
        s_msb      = sum_full[CHUNK-1];
        // Carry into the MSB recovered from the MSB sum bit and its two addends.
        c_into_msb = s_msb ^ a_chunk[CHUNK-1] ^ nb_chunk[CHUNK-1];
        ov         = c_into_msb ^ cout;
        chunk_eq   = (a_chunk == ~nb_chunk);
        last_chunk = (cnt_q == CW'(NCH - 1));
    end

    // Next-state and datapath update: accept in IDLE, walk chunks in RUN, publish result on the last one.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        eq_acc_d = eq_acc_q;
        sgn_d    = sgn_q;
        a_d      = a_q;
        nb_d     = nb_q;
        done_d   = 1'b0;
        lt_d     = lt_q;
        eq_d     = eq_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d  = S_RUN;
                    a_d      = a_i;
                    nb_d     = ~b_i;
                    sgn_d    = signed_i;
                    carry_d  = 1'b1;
                    cnt_d    = '0;
                    eq_acc_d = 1'b1;
                end
            end
            S_RUN: begin
                carry_d  = cout;
                eq_acc_d = eq_acc_q & chunk_eq;
                cnt_d    = cnt_q + 1'b1;
                if (last_chunk) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    // Signed: sign of the difference corrected for overflow. Unsigned: a borrow out means A < B.
                    lt_d    = sgn_q ? (s_msb ^ ov) : ~cout;
                    eq_d    = eq_acc_q & chunk_eq;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset clears everything so no input X can leak into results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            carry_q  <= 1'b1;
            eq_acc_q <= 1'b0;
            sgn_q    <= 1'b0;
            a_q      <= '0;
            nb_q     <= '0;
            done_q   <= 1'b0;
            lt_q     <= 1'b0;
            eq_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            eq_acc_q <= eq_acc_d;
            sgn_q    <= sgn_d;
            a_q      <= a_d;
            nb_q     <= nb_d;
            done_q   <= done_d;
            lt_q     <= lt_d;
            eq_q     <= eq_d;
        end
    end

    // Busy is exactly "a compare is in flight".
    always_comb begin
        busy_o = (state_q == S_RUN);
        done_o = done_q;
        lt_o   = lt_q;
        eq_o   = eq_q;
    end

endmodule

// File: tb/tb_seq_slt_unit.sv
// Bench for seq_slt_unit: three instances (16/4, 32/8, 16/16) checked against a cycle-level reference model.
// Latency: model expects done NCH edges after accept.
// Backpressure: starts issued while busy must be ignored by both DUT and model.
module tb_seq_slt_unit;

    logic        clk;
    logic        rst_n;
    logic        start_s [3];
    logic        sgn_s   [3];
    logic [31:0] a_s     [3];
    logic [31:0] b_s     [3];
    logic        busy    [3];
    logic        done    [3];
    logic        lt      [3];
    logic        eq      [3];

    int checks = 0;
    int errors = 0;

    seq_slt_unit #(.WIDTH(16), .CHUNK(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .start_i(start_s[0]), .signed_i(sgn_s[0]),
        .a_i(a_s[0][15:0]), .b_i(b_s[0][15:0]),
        .busy_o(busy[0]), .done_o(done[0]), .lt_o(lt[0]), .eq_o(eq[0])
    );

    seq_slt_unit #(.WIDTH(32), .CHUNK(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .start_i(start_s[1]), .signed_i(sgn_s[1]),
        .a_i(a_s[1]), .b_i(b_s[1]),
        .busy_o(busy[1]), .done_o(done[1]), .lt_o(lt[1]), .eq_o(eq[1])
    );

    seq_slt_unit #(.WIDTH(16), .CHUNK(16)) dut2 (
        .clk(clk), .rst_n(rst_n), .start_i(start_s[2]), .signed_i(sgn_s[2]),
        .a_i(a_s[2][15:0]), .b_i(b_s[2][15:0]),
        .busy_o(busy[2]), .done_o(done[2]), .lt_o(lt[2]), .eq_o(eq[2])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int wid(int k);
        return (k == 1) ? 32 : 16;
    endfunction

    function automatic int nch(int k);
        return (k == 2) ? 1 : 4;
    endfunction

    function automatic logic [31:0] msk(int k, logic [31:0] v);
        return (wid(k) == 32) ? v : (v & 32'h0000_FFFF);
    endfunction

    // Left-align to 32 bits: order is preserved, so native 32-bit compares give the WIDTH-bit answer.
    function automatic logic ref_lt(int k, logic [31:0] a, logic [31:0] b, logic s);
        logic [31:0] am;
        logic [31:0] bm;
        am = msk(k, a) << (32 - wid(k));
        bm = msk(k, b) << (32 - wid(k));
        if (s) return ($signed(am) < $signed(bm));
        return (am < bm);
    endfunction

    function automatic logic ref_eq(int k, logic [31:0] a, logic [31:0] b);
        return (msk(k, a) == msk(k, b));
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: cycles remaining in the current compare, result published when it reaches zero.
    int   m_rem  [3];
    logic m_done [3];
    logic m_lt   [3];
    logic m_eq   [3];
    logic p_lt   [3];
    logic p_eq   [3];

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 3; k++) begin
            if (!rst_n) begin
                m_rem[k]  <= 0;
                m_done[k] <= 1'b0;
                m_lt[k]   <= 1'b0;
                m_eq[k]   <= 1'b0;
                p_lt[k]   <= 1'b0;
                p_eq[k]   <= 1'b0;
            end else begin
                m_done[k] <= 1'b0;
                if (m_rem[k] > 0) begin
                    m_rem[k] <= m_rem[k] - 1;
                    if (m_rem[k] == 1) begin
                        m_done[k] <= 1'b1;
                        m_lt[k]   <= p_lt[k];
                        m_eq[k]   <= p_eq[k];
                    end
                end else if (start_s[k]) begin
                    m_rem[k] <= nch(k);
                    p_lt[k]  <= ref_lt(k, a_s[k], b_s[k], sgn_s[k]);
                    p_eq[k]  <= ref_eq(k, a_s[k], b_s[k]);
                end
            end
        end
    end

    // Every-cycle comparison of all instances against the model.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("model_busy%0d", k), busy[k], (m_rem[k] != 0));
            chk($sformatf("model_done%0d", k), done[k], m_done[k]);
            chk($sformatf("model_lt%0d", k), lt[k], m_lt[k]);
            chk($sformatf("model_eq%0d", k), eq[k], m_eq[k]);
        end
    end

    // Present a request, let it be taken on the next edge, then scramble the inputs.
    task automatic kick(int k, logic [31:0] a, logic [31:0] b, logic s);
        a_s[k]     = a;
        b_s[k]     = b;
        sgn_s[k]   = s;
        start_s[k] = 1'b1;
        @(posedge clk);
        #1;
        start_s[k] = 1'b0;
        a_s[k]     = $urandom;
        b_s[k]     = $urandom;
        sgn_s[k]   = 1'($urandom_range(0, 1));
        chk($sformatf("busy_after_accept%0d", k), busy[k], 1);
    endtask

    task automatic wait_done(int k, int lat, logic elt, logic eeq, string name);
        int n;
        n = 0;
        while (n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (done[k]) break;
        end
        chk({name, "_lat"}, n, lat);
        chk({name, "_lt"}, lt[k], elt);
        chk({name, "_eq"}, eq[k], eeq);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int dcnt;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            start_s[k] = 1'b0;
            sgn_s[k]   = 1'b0;
            a_s[k]     = '0;
            b_s[k]     = '0;
        end
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_busy%0d", k), busy[k], 0);
            chk($sformatf("rst_done%0d", k), done[k], 0);
            chk($sformatf("rst_lt%0d", k), lt[k], 0);
            chk($sformatf("rst_eq%0d", k), eq[k], 0);
        end
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic signed/unsigned, overflow and equality cases (some issued back-to-back on done).
        kick(0, 32'hFFFF, 32'h0001, 1'b1); wait_done(0, 4, 1'b1, 1'b0, "t1_signed");
        kick(0, 32'hFFFF, 32'h0001, 1'b0); wait_done(0, 4, 1'b0, 1'b0, "t1_unsigned");
        kick(0, 32'h8000, 32'h7FFF, 1'b1); wait_done(0, 4, 1'b1, 1'b0, "t2_ovf_signed");
        kick(0, 32'h8000, 32'h7FFF, 1'b0); wait_done(0, 4, 1'b0, 1'b0, "t2_ovf_unsigned");
        kick(0, 32'h7FFF, 32'h8000, 1'b1); wait_done(0, 4, 1'b0, 1'b0, "t2_rev_signed");
        kick(0, 32'h1234, 32'h1234, 1'b1); wait_done(0, 4, 1'b0, 1'b1, "t3_eq_signed");
        kick(0, 32'h1234, 32'h1234, 1'b0); wait_done(0, 4, 1'b0, 1'b1, "t3_eq_unsigned");
        kick(0, 32'h1234, 32'h1235, 1'b0); wait_done(0, 4, 1'b1, 1'b0, "t3_lsb_diff");

        // Start while busy with operands that would give eq=1 must be dropped.
        @(posedge clk); #1;
        kick(0, 32'hFFFF, 32'h0001, 1'b1);
        @(posedge clk); #1;
        start_s[0] = 1'b1; a_s[0] = 32'h0; b_s[0] = 32'h0; sgn_s[0] = 1'b0;
        @(posedge clk); #1;
        start_s[0] = 1'b0; a_s[0] = 32'h5555;
        wait_done(0, 2, 1'b1, 1'b0, "t4_ignore_busy");
        chk("t4_done_before_b2b", done[0], 1);
        kick(0, 32'h0003, 32'h0003, 1'b0);
        chk("t4_done_fell", done[0], 0);
        wait_done(0, 4, 1'b0, 1'b1, "t4_b2b");

        // Asynchronous reset two edges into a run.
        kick(0, 32'h0001, 32'h0002, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("t5_busy", busy[0], 0);
        chk("t5_done", done[0], 0);
        chk("t5_lt", lt[0], 0);
        chk("t5_eq", eq[0], 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        dcnt = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (done[0]) dcnt++;
        end
        chk("t5_no_done_after_reset", dcnt, 0);
        kick(0, 32'h0001, 32'h0002, 1'b1); wait_done(0, 4, 1'b1, 1'b0, "t5_fresh");

        // Parameter sweep on the 32/8 and 16/16 instances.
        for (int i = 0; i < 12; i++) begin
            for (int k = 1; k < 3; k++) begin
                ra = $urandom;
                rb = (i % 3 == 0) ? ra : $urandom;
                if (i == 1) begin
                    ra = 32'h8000_8000;
                    rb = 32'h7FFF_7FFF;
                end
                rs = 1'(i % 2);
                kick(k, ra, rb, rs);
                wait_done(k, nch(k), ref_lt(k, ra, rb, rs), ref_eq(k, ra, rb),
                          $sformatf("t6_k%0d_i%0d", k, i));
                @(posedge clk); #1;
                chk($sformatf("t6_pulse_k%0d_i%0d", k, i), done[k], 0);
            end
        end

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
